boot_loader: RTL and testbench
==============================

# boot_loader

UART boot and console controller between the UART receiver/transmitter pair and the CPU core. It receives a program image over UART, writes it word by word into instruction memory, and holds the core in reset until the image is complete. It then acknowledges the host and releases the core. While the core runs, it schedules the core's output words onto the shared transmitter.

## Interface
Parameters:
- `CLK_PER_HALF_BIT`, 5208: passed through for documentation only; no internal timing depends on it.
- `IMEM_WORDS`, 32: instruction memory depth in 32-bit words; legal 1..256.
- `ADDR_W`, 5: instruction address width; must equal clog2(`IMEM_WORDS`).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, **asynchronous, active-high**.
- `rx_data` in 8: received byte; valid while `rx_ready` is high.
- `rx_ready` in 1: one-cycle pulse per received byte.
- `ferr` in 1: framing error; qualifies the same cycle as `rx_ready`.
- `imem_we` out 1: instruction memory write strobe, one cycle wide.
- `imem_addr` out `ADDR_W`: word address.
- `imem_wdata` out 32: instruction word.
- `core_rstn` out 1: core reset, active-low; low until the program is loaded.
- `out_word` in 32: core output register.
- `out_valid` in 1: one-cycle pulse when the core produces output.
- `tx_data` out 8: byte to the transmitter.
- `tx_start` out 1: one-cycle transmit request.
- `tx_busy` in 1: transmitter busy.
- `state_o` out 3: current state, for debug.
- `ovf` out 1: sticky flag; an output byte was dropped.

## Operation
States: IDLE, LOAD, ACK, RUN, ERR.

- **IDLE:** the first `rx_ready` byte is the word count N.
  - N = 0 or N > `IMEM_WORDS` → ERR.
  - Otherwise latch N, clear the byte counter and address → LOAD.
- **LOAD:** bytes are little-endian, so byte k of a word fills bits [8k+7:8k].
  - On the 4th byte, assert `imem_we` with the assembled word at the current address, then increment the address.
  - After word N−1 is written → ACK.
- **ACK:** queue byte 0xAA for transmit. After its `tx_start` pulse → RUN. `core_rstn` goes high on RUN entry.
- **RUN:** `rx_ready` is ignored.
  - On `out_valid`: if the pending buffer is empty, capture `out_word[7:0]` into it.
  - If the buffer is full, drop the byte and set `ovf`.
- **ERR:** queue byte 0xEE once, then stay in ERR; `core_rstn` stays low.
  - Exit only through `rst`.
- **Framing error:** `rx_ready` with `ferr` in IDLE or LOAD → ERR; the byte is discarded.
- **Transmit scheduler (all states):** a one-entry pending buffer.
  - `tx_start` pulses when the buffer is full and `tx_busy` is low, and no `tx_start` was issued in the previous cycle.
  - The buffer empties in the `tx_start` cycle.

## Timing
- **Reset values:**
  - `core_rstn` 0; `imem_we`, `tx_start`, `ovf` 0; `imem_addr`, `imem_wdata`, `tx_data` 0.
  - `state_o` = IDLE. Reset asserted mid-load or mid-run returns all of these values asynchronously.
- **Write latency:** `imem_we` is high the cycle after the 4th byte's `rx_ready`. Address and data are stable in that same cycle.
- **ACK and release:**
  - ACK `tx_start` no earlier than 1 cycle after the last `imem_we`, gated by `tx_busy`.
  - `core_rstn` rises the cycle after that `tx_start`.
- **Transmit spacing:** minimum 2 cycles between `tx_start` pulses, which covers the 1-cycle delay before `tx_busy` rises.
- **Same-cycle `out_valid` and `tx_start`:** the buffer drains and accepts the new byte; no drop.
- **Last address:** `imem_addr` saturates at N−1 and does not wrap.

## Structure
- Shared package `boot_pkg`: state encoding, `ACK_BYTE` = 8'hAA, `ERR_BYTE` = 8'hEE.
- One sub-module, `tx_sched`: the one-entry pending buffer plus `tx_start` generation. It is reused by the ACK, ERR and RUN paths.
- The FSM and word assembler live in `boot_loader`.

## Test plan
- **Normal load:** send N=3, then 12 bytes forming 0x00100093, 0x00100113, 0x00200213.
  - Expect three `imem_we` pulses at addresses 0/1/2 with those words.
  - Expect `tx_data` 0xAA, then `core_rstn` high.
- **Bad count:** N=0 and, separately, N=33 → `tx_data` 0xEE, `core_rstn` stays 0, state ERR.
- **Framing error:** `ferr` on byte 6 of a load → no further `imem_we`, 0xEE sent, ERR held until `rst`.
- **Run forwarding:**
  - `out_valid` with `out_word` 0x00000037 while idle → one `tx_start` with 0x37.
  - Second `out_valid` while busy with the buffer full → `ovf` = 1 and only the first byte is sent.
- **Reset mid-load:** assert `rst` after 2 words are written → all outputs reach reset values. A fresh N=1 load then succeeds at address 0.
- **Bytes ignored in RUN:** `rx_ready` bytes during RUN → no `imem_we` and no state change.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg
// Items shared by the UART boot loader files:
//   - state_e  : FSM state encoding, which is also exported on state_o
//   - ACK_BYTE : byte sent to the host once the image is fully loaded
//   - ERR_BYTE : byte sent to the host when a load is rejected or aborted
//   - count_ok : checks a received word count against the memory depth
// -----------------------------------------------------------------------------
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ACK  = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam logic [7:0] ACK_BYTE = 8'hAA;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  // A word count is usable when it is non-zero and fits in instruction memory.
  function automatic logic count_ok(input logic [7:0] n, input int unsigned max_words);
    return (n != 8'd0) && (32'(n) <= max_words);
  endfunction

endpackage

// File: rtl/boot_loader_tx_sched.sv
// -----------------------------------------------------------------------------
// tx_sched
// One-entry pending buffer in front of the shared UART transmitter. The ACK,
// ERR and RUN paths all push bytes through this buffer.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_push        : request to queue i_push_data (one cycle)
//   i_push_data   : byte to queue
//   i_tx_busy     : transmitter busy
//   o_tx_data     : byte presented to the transmitter (holds the last byte sent)
//   o_tx_start    : one-cycle transmit request
//   o_drop        : pulses when a push is refused because the buffer is full
// -----------------------------------------------------------------------------
module tx_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_push_data,
  input  logic       i_tx_busy,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  output logic       o_drop
);

  logic       r_full;
  logic [7:0] r_buf;
  logic [7:0] r_tx_data;
  logic       r_tx_start;
  logic       w_fire;

  // Launch only when the previous cycle held no request. That gap covers the
  // one cycle the transmitter needs before its busy flag rises.
  assign w_fire = r_full & ~i_tx_busy & ~r_tx_start;

  // A push that coincides with a launch refills the slot being drained.
  assign o_drop = i_push & r_full & ~w_fire;

  // NOTE: state registers use non-blocking assignments, so every branch below
  // reads the values from before this clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full     <= 1'b0;
      r_buf      <= 8'h00;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= w_fire;
      if (w_fire) begin
        r_tx_data <= r_buf;
      end
      if (i_push && (!r_full || w_fire)) begin
        r_full <= 1'b1;
        r_buf  <= i_push_data;
      end else if (w_fire) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;

endmodule

// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
// UART boot and console controller. A host sends a word count and then a
// little-endian program image. The controller writes the image into
// instruction memory while the core is held in reset. It then sends 0xAA to
// the host and releases the core. After that it forwards the low byte of each
// core output word to the transmitter. A bad count or a framing error sends
// 0xEE, and the block stays in ERR until reset.
//
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   rx_data, rx_ready, ferr       : UART receiver byte, strobe, framing error
//   imem_we, imem_addr, imem_wdata: instruction memory write port
//   core_rstn                     : core reset, active-low
//   out_word, out_valid           : core output word and strobe
//   tx_data, tx_start, tx_busy    : UART transmitter interface
//   state_o                       : current FSM state, for debug
//   ovf                           : sticky flag, an output byte was dropped
// -----------------------------------------------------------------------------
module boot_loader
  import boot_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int IMEM_WORDS       = 32,
  parameter int ADDR_W           = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              ferr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rstn,
  input  logic [31:0]       out_word,
  input  logic              out_valid,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [2:0]        state_o,
  output logic              ovf
);

  // The bit period belongs to the UART pair; it is checked here only so that
  // a bad configuration fails at elaboration.
  if (IMEM_WORDS < 1 || IMEM_WORDS > 256 || ADDR_W != $clog2(IMEM_WORDS) ||
      CLK_PER_HALF_BIT < 1) begin : g_bad_params
    $error("boot_loader: illegal parameter combination");
  end

  state_e            r_state;
  logic [ADDR_W-1:0] r_n_last;     // index of the final word (N-1)
  logic [ADDR_W-1:0] r_word_idx;   // word being assembled
  logic [1:0]        r_byte_idx;   // byte position inside the current word
  logic [23:0]       r_asm;        // bytes 0..2 of the current word
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_core_rstn;
  logic              r_q_push;     // one-shot push of ACK/ERR byte
  logic [7:0]        r_q_data;
  logic              r_ovf;

  logic              w_push;
  logic [7:0]        w_push_data;
  logic              w_tx_start;
  logic              w_drop;
  logic [23:0]       w_unused_out_hi;

  assign w_unused_out_hi = out_word[31:8];

  // Only the low byte of a core output word is forwarded, and only in RUN.
  // The ACK/ERR one-shot cannot overlap RUN traffic: RUN is entered only
  // after the ACK byte has left the buffer.
  assign w_push      = r_q_push | ((r_state == ST_RUN) & out_valid);
  assign w_push_data = r_q_push ? r_q_data : out_word[7:0];

  tx_sched u_tx_sched (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_tx_busy   (tx_busy),
    .o_tx_data   (tx_data),
    .o_tx_start  (w_tx_start),
    .o_drop      (w_drop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_n_last     <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= 2'd0;
      r_asm        <= 24'h0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= 32'h0;
      r_core_rstn  <= 1'b0;
      r_q_push     <= 1'b0;
      r_q_data     <= 8'h00;
      r_ovf        <= 1'b0;
    end else begin
      // NOTE: strobes fall back to 0 every cycle and are raised only by the
      // branch that needs them, which keeps them exactly one cycle wide.
      r_imem_we <= 1'b0;
      r_q_push  <= 1'b0;

      if (w_drop) begin
        r_ovf <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (rx_ready) begin
            if (ferr || !count_ok(rx_data, IMEM_WORDS)) begin
              r_state  <= ST_ERR;
              r_q_push <= 1'b1;
              r_q_data <= ERR_BYTE;
            end else begin
              r_n_last   <= ADDR_W'(rx_data - 8'd1);
              r_word_idx <= '0;
              r_byte_idx <= 2'd0;
              r_state    <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (rx_ready) begin
            if (ferr) begin
              r_state  <= ST_ERR;
              r_q_push <= 1'b1;
              r_q_data <= ERR_BYTE;
            end else begin
              r_byte_idx <= r_byte_idx + 2'd1;
              if (r_byte_idx == 2'd3) begin
                r_imem_we    <= 1'b1;
                r_imem_addr  <= r_word_idx;
                r_imem_wdata <= {rx_data, r_asm};
                // The index stops at N-1, so the address never wraps.
                if (r_word_idx == r_n_last) begin
                  r_state  <= ST_ACK;
                  r_q_push <= 1'b1;
                  r_q_data <= ACK_BYTE;
                end else begin
                  r_word_idx <= r_word_idx + ADDR_W'(1);
                end
              end else begin
                r_asm[{r_byte_idx, 3'b000} +: 8] <= rx_data;
              end
            end
          end
        end

        ST_ACK: begin
          // The only byte in flight in ACK is 0xAA, so its launch releases
          // the core on the following cycle.
          if (w_tx_start) begin
            r_state     <= ST_RUN;
            r_core_rstn <= 1'b1;
          end
        end

        ST_RUN: begin
          // Received bytes are ignored. Core output is pushed combinationally.
        end

        ST_ERR: begin
          // Stays here until reset.
        end

        default: begin
          r_state <= ST_ERR;
        end
      endcase
    end
  end

  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign core_rstn  = r_core_rstn;
  assign tx_start   = w_tx_start;
  assign state_o    = r_state;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_boot_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_boot_loader
// Feeds byte streams and core output words into boot_loader and compares
// the memory writes, transmitted bytes and control outputs with values the
// bench works out from the image contents and the protocol rules.
// -----------------------------------------------------------------------------
module tb_boot_loader;

  localparam int IMEM_WORDS = 32;
  localparam int ADDR_W     = 5;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready = 1'b0;
  logic              ferr = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rstn;
  logic [31:0]       out_word = 32'h0;
  logic              out_valid = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy = 1'b0;
  logic [2:0]        state_o;
  logic              ovf;

  boot_loader #(.CLK_PER_HALF_BIT(5208), .IMEM_WORDS(IMEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .ferr       (ferr),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rstn  (core_rstn),
    .out_word   (out_word),
    .out_valid  (out_valid),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .state_o    (state_o),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] img [256];
  int          wq_addr [$];
  logic [31:0] wq_data [$];
  logic [7:0]  txq [$];
  int          tx_cyc [$];
  int          cyc = 0;
  int          last_we_cyc = -1;
  int          rise_cyc = -1;
  int          spacing_viol = 0;
  bit          auto_busy = 1'b1;

  // Records every memory write and every transmit launch.
  initial begin
    bit prev_start = 1'b0;
    bit prev_rstn  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_start = 1'b0;
        prev_rstn  = 1'b0;
      end else begin
        if (imem_we) begin
          wq_addr.push_back(int'(imem_addr));
          wq_data.push_back(imem_wdata);
          last_we_cyc = cyc;
        end
        if (tx_start) begin
          txq.push_back(tx_data);
          tx_cyc.push_back(cyc);
          if (prev_start) spacing_viol++;
        end
        if (core_rstn && !prev_rstn) rise_cyc = cyc;
        prev_start = tx_start;
        prev_rstn  = core_rstn;
      end
    end
  end

  // Transmitter model: busy rises one cycle after tx_start and stays high for 3 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_busy && tx_start) begin
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rx_ready  = 1'b0;
    ferr      = 1'b0;
    out_valid = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    wq_addr.delete();
    wq_data.delete();
    txq.delete();
    tx_cyc.delete();
    last_we_cyc = -1;
    rise_cyc    = -1;
    #1 rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit fe);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_ready = 1'b1;
    ferr     = fe;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    ferr     = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Sends a count followed by words img[0..n-1]. After each 4th byte it checks
  // that the write is visible in the very next cycle.
  task automatic send_load(input int n);
    logic [31:0] w;
    send_byte(8'(n), 1'b0);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b0);
      tests_run++;
      if (imem_we !== 1'b1 || imem_addr !== ADDR_W'(i) || imem_wdata !== w) begin
        tests_failed++;
        $display("FAIL write_latency word %0d: got we=%b addr=%0d data=%h, required we=1 addr=%0d data=%h",
                 i, imem_we, imem_addr, imem_wdata, i, w);
      end
    end
  endtask

  task automatic wait_tx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && txq.size() < n; i++) @(negedge clk);
    if (txq.size() >= n) ok = 1'b1;
  endtask

  task automatic pulse_out(input logic [31:0] w);
    @(posedge clk);
    #1;
    out_word  = w;
    out_valid = 1'b1;
    @(posedge clk);
    #1;
    out_valid = 1'b0;
  endtask

  // Loads n words from img and verifies all writes, the ACK byte and the core release.
  task automatic load_and_verify(input int n, input string tag);
    bit ok;
    send_load(n);
    wait_tx(1, 100, ok);
    repeat (2) @(negedge clk);
    tests_run++;
    if (wq_addr.size() != n) begin
      tests_failed++;
      $display("FAIL %s write_count: got %0d, required %0d", tag, wq_addr.size(), n);
    end
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      tests_run++;
      if (wq_addr[i] != i || wq_data[i] !== img[i]) begin
        tests_failed++;
        $display("FAIL %s write[%0d]: got addr=%0d data=%h, required addr=%0d data=%h",
                 tag, i, wq_addr[i], wq_data[i], i, img[i]);
      end
    end
    tests_run++;
    if (!ok || txq[0] !== 8'hAA) begin
      tests_failed++;
      $display("FAIL %s ack_byte: got %0d bytes first=%h, required AA", tag, txq.size(),
               (txq.size() > 0) ? txq[0] : 8'hxx);
    end
    tests_run++;
    if (!ok || rise_cyc != tx_cyc[0] + 1 || tx_cyc[0] < last_we_cyc + 1) begin
      tests_failed++;
      $display("FAIL %s release_timing: got ack_cyc=%0d rise_cyc=%0d last_we=%0d, required rise=ack+1, ack>last_we",
               tag, (tx_cyc.size() > 0) ? tx_cyc[0] : -1, rise_cyc, last_we_cyc);
    end
    tests_run++;
    if (state_o !== S_RUN || core_rstn !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s run_state: got state=%0d core_rstn=%b, required state=3 core_rstn=1",
               tag, state_o, core_rstn);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests_run++;
    if (core_rstn !== 1'b0 || imem_we !== 1'b0 || tx_start !== 1'b0 || ovf !== 1'b0 ||
        imem_addr !== '0 || imem_wdata !== 32'h0 || tx_data !== 8'h00 || state_o !== S_IDLE) begin
      tests_failed++;
      $display("FAIL reset_values: got rstn=%b we=%b start=%b ovf=%b addr=%0d wdata=%h tx=%h st=%0d, required all zero",
               core_rstn, imem_we, tx_start, ovf, imem_addr, imem_wdata, tx_data, state_o);
    end
    do_reset();
  endtask

  task automatic test_normal_load();
    do_reset();
    auto_busy = 1'b1;
    img[0] = 32'h00100093;
    img[1] = 32'h00100113;
    img[2] = 32'h00200213;
    load_and_verify(3, "normal");
  endtask

  task automatic test_random_load();
    int sizes [3];
    sizes[0] = IMEM_WORDS;
    sizes[1] = 1;
    sizes[2] = $urandom_range(2, IMEM_WORDS - 1);
    for (int k = 0; k < 3; k++) begin
      do_reset();
      for (int i = 0; i < sizes[k]; i++) img[i] = $urandom;
      load_and_verify(sizes[k], $sformatf("random_n%0d", sizes[k]));
    end
  endtask

  task automatic test_bad_count();
    int counts [3];
    bit ok;
    counts[0] = 0;
    counts[1] = IMEM_WORDS + 1;
    counts[2] = $urandom_range(IMEM_WORDS + 2, 255);
    for (int k = 0; k < 3; k++) begin
      do_reset();
      send_byte(8'(counts[k]), 1'b0);
      wait_tx(1, 50, ok);
      repeat (20) @(negedge clk);
      tests_run++;
      if (!ok || txq.size() != 1 || txq[0] !== 8'hEE || state_o !== S_ERR ||
          core_rstn !== 1'b0 || wq_addr.size() != 0) begin
        tests_failed++;
        $display("FAIL bad_count_%0d: got bytes=%0d first=%h st=%0d rstn=%b writes=%0d, required one EE, st=4, rstn=0, no writes",
                 counts[k], txq.size(), (txq.size() > 0) ? txq[0] : 8'hxx, state_o, core_rstn, wq_addr.size());
      end
    end
  endtask

  task automatic test_framing();
    bit ok;
    do_reset();
    img[0] = $urandom;
    send_byte(8'd3, 1'b0);
    for (int b = 0; b < 4; b++) send_byte(img[0][8*b +: 8], 1'b0);
    send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b1);
    wait_tx(1, 50, ok);
    tests_run++;
    if (!ok || txq[0] !== 8'hEE || state_o !== S_ERR) begin
      tests_failed++;
      $display("FAIL framing_err_byte: got bytes=%0d st=%0d, required EE and st=4", txq.size(), state_o);
    end
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'($urandom));
    repeat (10) @(negedge clk);
    tests_run++;
    if (wq_addr.size() != 1 || wq_data[0] !== img[0] || txq.size() != 1 ||
        state_o !== S_ERR || core_rstn !== 1'b0) begin
      tests_failed++;
      $display("FAIL framing_hold: got writes=%0d bytes=%0d st=%0d rstn=%b, required writes=1 bytes=1 st=4 rstn=0",
               wq_addr.size(), txq.size(), state_o, core_rstn);
    end
    do_reset();
    tests_run++;
    if (state_o !== S_IDLE) begin
      tests_failed++;
      $display("FAIL framing_exit: got st=%0d, required 0 after reset", state_o);
    end
  endtask

  task automatic enter_run();
    bit ok;
    do_reset();
    auto_busy = 1'b1;
    img[0] = $urandom;
    send_load(1);
    wait_tx(1, 100, ok);
    repeat (10) @(negedge clk);
    auto_busy = 1'b0;
    tx_busy   = 1'b0;
    txq.delete();
    tx_cyc.delete();
  endtask

  task automatic test_run_forwarding();
    bit ok;
    logic [7:0] a;
    logic [7:0] b;
    enter_run();
    pulse_out({24'($urandom), 8'h37});
    wait_tx(1, 20, ok);
    repeat (3) @(negedge clk);
    tests_run++;
    if (!ok || txq.size() != 1 || txq[0] !== 8'h37 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL fwd_single: got bytes=%0d first=%h ovf=%b, required one 37, ovf=0",
               txq.size(), (txq.size() > 0) ? txq[0] : 8'hxx, ovf);
    end
    a = 8'($urandom);
    b = a ^ 8'h5A;
    tx_busy = 1'b1;
    pulse_out({24'($urandom), a});
    pulse_out({24'($urandom), b});
    repeat (3) @(negedge clk);
    tests_run++;
    if (ovf !== 1'b1 || txq.size() != 1) begin
      tests_failed++;
      $display("FAIL fwd_overflow: got ovf=%b bytes=%0d, required ovf=1 bytes=1", ovf, txq.size());
    end
    tx_busy = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++;
    if (txq.size() != 2 || txq[1] !== a || ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL fwd_first_kept: got bytes=%0d last=%h ovf=%b, required 2 bytes, last=%h, ovf=1",
               txq.size(), (txq.size() > 1) ? txq[1] : 8'hxx, ovf, a);
    end
  endtask

  task automatic test_same_cycle();
    logic [7:0] x;
    logic [7:0] y;
    bit hit = 1'b0;
    enter_run();
    x = 8'($urandom);
    y = ~x;
    pulse_out({24'h0, x});
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (tx_start) begin
        hit       = 1'b1;
        out_word  = {24'($urandom), y};
        out_valid = 1'b1;
        @(posedge clk);
        #1 out_valid = 1'b0;
      end
    end
    repeat (10) @(negedge clk);
    tests_run++;
    if (!hit || txq.size() != 2 || txq[0] !== x || txq[1] !== y || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_cycle: got hit=%b bytes=%0d ovf=%b, required bytes %h,%h and ovf=0",
               hit, txq.size(), ovf, x, y);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    auto_busy = 1'b1;
    for (int i = 0; i < 4; i++) img[i] = $urandom | 32'h1;
    send_byte(8'd4, 1'b0);
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 4; b++) send_byte(img[i][8*b +: 8], 1'b0);
    send_byte(img[2][7:0], 1'b0);
    tests_run++;
    if (wq_addr.size() != 2) begin
      tests_failed++;
      $display("FAIL midload_writes: got %0d, required 2", wq_addr.size());
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (core_rstn !== 1'b0 || imem_we !== 1'b0 || tx_start !== 1'b0 || ovf !== 1'b0 ||
        imem_addr !== '0 || imem_wdata !== 32'h0 || tx_data !== 8'h00 || state_o !== S_IDLE) begin
      tests_failed++;
      $display("FAIL midload_async_reset: got rstn=%b we=%b start=%b ovf=%b addr=%0d wdata=%h tx=%h st=%0d, required all zero",
               core_rstn, imem_we, tx_start, ovf, imem_addr, imem_wdata, tx_data, state_o);
    end
    do_reset();
    img[0] = $urandom;
    load_and_verify(1, "fresh_after_reset");
  endtask

  task automatic test_run_ignores_rx();
    wq_addr.delete();
    wq_data.delete();
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'($urandom));
    repeat (5) @(negedge clk);
    tests_run++;
    if (wq_addr.size() != 0 || state_o !== S_RUN || core_rstn !== 1'b1) begin
      tests_failed++;
      $display("FAIL run_ignores_rx: got writes=%0d st=%0d rstn=%b, required 0 writes, st=3, rstn=1",
               wq_addr.size(), state_o, core_rstn);
    end
  endtask

  initial begin
    test_reset();
    test_normal_load();
    test_run_ignores_rx();
    test_random_load();
    test_bad_count();
    test_framing();
    test_run_forwarding();
    test_same_cycle();
    test_reset_mid_load();
    tests_run++;
    if (spacing_viol != 0) begin
      tests_failed++;
      $display("FAIL tx_spacing: got %0d back-to-back tx_start pairs, required 0", spacing_viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
